// File: rtl/uart_tx_sched.sv
// uart_tx_sched
//   Shares one UART transmit line between NUM_REQ requesters. A round-robin
//   arbiter accepts one byte at a time while idle, and each accepted byte is
//   sent as an 8N1 frame (start, 8 data bits LSB first, stop). The local
//   receiver enable is held low for the whole frame plus GUARD_BITS bit
//   times, so the receiver never hears our own transmission.
//
//   Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
//   between the last data bit and the stop bit (8E1 framing).
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  per-requester byte valid
//   req_data   requester i byte at [8i+7:8i]
//   req_ready  one-hot accept, combinational, only while idle
//   grant_id   index of the most recently accepted requester
//   busy       frame or guard time in progress
//   tx         UART serial output, idle high
//   rx_enable  receiver enable, low while transmitting and during guard

module uart_tx_sched #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int GUARD_BITS   = 1,
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int BW  = $clog2(CLKS_PER_BIT)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [IDW-1:0]         grant_id,
  output logic                   busy,
  output logic                   tx,
  output logic                   rx_enable
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    GUARD  = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic           tx_q, tx_d;
  logic           rxen_q, rxen_d;
  logic           busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW:0]   cand;
  logic [IDW:0]   ptr_inc;
  logic [IDW-1:0] ptr_nxt;
  logic [7:0]     win_byte;
  logic           baud_wrap;

  // Round-robin search: walk upward from the pointer, wrapping at NUM_REQ.
  // cand carries one extra bit so ptr+k never overflows before the wrap test.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NUM_REQ)) cand = cand - (IDW+1)'(NUM_REQ);
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    ptr_inc = {1'b0, win_idx} + 1'b1;
    ptr_nxt = (ptr_inc == (IDW+1)'(NUM_REQ)) ? '0 : ptr_inc[IDW-1:0];
  end

  assign win_byte = req_data[{win_idx, 3'b000} +: 8];

  // Gated by reset so nothing can be accepted while the block is held in reset.
  assign req_ready = (reset && (state_q == IDLE) && win_found)
                     ? (NUM_REQ'(1) << win_idx) : '0;

  assign baud_wrap = (baud_q == BW'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    grant_d = grant_q;
    tx_d    = tx_q;
    rxen_d  = rxen_q;
    busy_d  = busy_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) baud_d = baud_wrap ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          shift_d = win_byte;
          grant_d = win_idx;
          ptr_d   = ptr_nxt;
          state_d = START;
          tx_d    = 1'b0;
          rxen_d  = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
`ifdef UART_TX_PARITY_EN
          par_d   = ^win_byte;
`endif
        end
      end
      START: begin
        // Present bit 0 and pre-shift so shift_q[0] always holds the next bit.
        if (baud_wrap) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_wrap) begin
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_wrap) begin
          if (GUARD_BITS > 0) begin
            state_d = GUARD;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
            rxen_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      GUARD: begin
        // bit_q counts elapsed guard bit times.
        if (baud_wrap) begin
          if (bit_q == 3'(GUARD_BITS - 1)) begin
            state_d = IDLE;
            rxen_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bit_d   = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        rxen_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      grant_q <= '0;
      tx_q    <= 1'b1;
      rxen_q  <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      grant_q <= grant_d;
      tx_q    <= tx_d;
      rxen_q  <= rxen_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign grant_id  = grant_q;
  assign busy      = busy_q;
  assign tx        = tx_q;
  assign rx_enable = rxen_q;

endmodule
